// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a 2x2 pixel array: erase, expose, ramp conversion,
// then per-pixel readout onto a valid/ready stream.
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       START,
  output logic       BUSY,
  output logic       ERASE,
  output logic       RESET,
  output logic       EXPOSE,
  output logic       RAMP_EN,
  output logic       READ1,
  output logic       READ2,
  output logic       READ3,
  output logic       READ4,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  input  logic [7:0] DATA_IN,
  output logic [7:0] PIX_DATA,
  output logic [1:0] PIX_IDX,
  output logic       PIX_VALID,
  input  logic       PIX_READY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_TURN,
    S_RD_SETTLE,
    S_RD_CAPTURE,
    S_RD_OUT
  } state_t;

  localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'd255;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] timer;
  logic [1:0]  idx;
  logic        rd_en;
  logic        xfer;

  assign xfer = (state == S_RD_OUT) && PIX_READY;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Phase timer; restarts on every state change, low byte is the ramp count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      timer <= '0;
    end else if (state inside {S_ERASE, S_EXPOSE, S_CONVERT}) begin
      timer <= timer + 16'd1;
    end
  end

  // Pixel index, captured code and end-of-frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      PIX_DATA   <= '0;
      PIX_IDX    <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= xfer && (idx == 2'd3);
      if (state == S_TURN) begin
        idx <= '0;
      end else if (xfer && (idx != 2'd3)) begin
        idx <= idx + 2'd1;
      end
      if (state == S_RD_CAPTURE) begin
        PIX_DATA <= DATA_IN;
        PIX_IDX  <= idx;
      end
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (START) state_nxt = S_ERASE;
      S_ERASE:      if (timer == ERASE_LAST) state_nxt = S_EXPOSE;
      S_EXPOSE:     if (timer == EXPOSE_LAST) state_nxt = S_CONVERT;
      S_CONVERT:    if (timer == CONV_LAST) state_nxt = S_TURN;
      S_TURN:       state_nxt = S_RD_SETTLE;
      S_RD_SETTLE:  state_nxt = S_RD_CAPTURE;
      S_RD_CAPTURE: state_nxt = S_RD_OUT;
      S_RD_OUT: begin
        if (PIX_READY) begin
          state_nxt = (idx == 2'd3) ? S_IDLE : S_RD_SETTLE;
        end
      end
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Output decode; bus drive and read strobes live in disjoint states
  always_comb begin
    BUSY      = (state != S_IDLE);
    ERASE     = 1'b0;
    RESET     = 1'b0;
    EXPOSE    = 1'b0;
    RAMP_EN   = 1'b0;
    DATA_OE   = 1'b0;
    DATA_OUT  = '0;
    PIX_VALID = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      S_ERASE: begin
        ERASE = 1'b1;
        RESET = 1'b1;
      end
      S_EXPOSE: EXPOSE = 1'b1;
      S_CONVERT: begin
        RAMP_EN  = 1'b1;
        DATA_OE  = 1'b1;
        DATA_OUT = timer[7:0];
      end
      S_RD_SETTLE, S_RD_CAPTURE: rd_en = 1'b1;
      S_RD_OUT: PIX_VALID = 1'b1;
      default: ;
    endcase
    READ1 = rd_en && (idx == 2'd0);
    READ2 = rd_en && (idx == 2'd1);
    READ3 = rd_en && (idx == 2'd2);
    READ4 = rd_en && (idx == 2'd3);
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: cycle-table checks of a frame,
// backpressure, ignored START, mid-frame reset and minimum timing.
module tb_pixel_array_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       START, BUSY, ERASE, RESET, EXPOSE, RAMP_EN;
  logic       READ1, READ2, READ3, READ4;
  logic [7:0] DATA_OUT, DATA_IN, PIX_DATA;
  logic       DATA_OE, PIX_VALID, PIX_READY, FRAME_DONE;
  logic [1:0] PIX_IDX;

  logic       START_b, BUSY_b, ERASE_b, RESET_b, EXPOSE_b, RAMP_EN_b;
  logic       READ1_b, READ2_b, READ3_b, READ4_b;
  logic [7:0] DATA_OUT_b, DATA_IN_b, PIX_DATA_b;
  logic       DATA_OE_b, PIX_VALID_b, PIX_READY_b, FRAME_DONE_b;
  logic [1:0] PIX_IDX_b;

  int nrun = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pixel_array_ctrl dut (
    .clk(clk), .reset_n(reset_n), .START(START), .BUSY(BUSY),
    .ERASE(ERASE), .RESET(RESET), .EXPOSE(EXPOSE), .RAMP_EN(RAMP_EN),
    .READ1(READ1), .READ2(READ2), .READ3(READ3), .READ4(READ4),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
    .PIX_DATA(PIX_DATA), .PIX_IDX(PIX_IDX), .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY), .FRAME_DONE(FRAME_DONE)
  );

  pixel_array_ctrl #(.ERASE_CYCLES(1), .EXPOSE_CYCLES(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .START(START_b), .BUSY(BUSY_b),
    .ERASE(ERASE_b), .RESET(RESET_b), .EXPOSE(EXPOSE_b),
    .RAMP_EN(RAMP_EN_b), .READ1(READ1_b), .READ2(READ2_b),
    .READ3(READ3_b), .READ4(READ4_b), .DATA_OUT(DATA_OUT_b),
    .DATA_OE(DATA_OE_b), .DATA_IN(DATA_IN_b), .PIX_DATA(PIX_DATA_b),
    .PIX_IDX(PIX_IDX_b), .PIX_VALID(PIX_VALID_b),
    .PIX_READY(PIX_READY_b), .FRAME_DONE(FRAME_DONE_b)
  );

  assign DATA_IN_b   = 8'h5A;
  assign PIX_READY_b = 1'b1;

  // Pixel model: each pixel latches the ramp value matching its code
  logic [7:0] code [4] = '{8'd17, 8'd200, 8'd0, 8'd255};
  logic [7:0] lat [4];
  logic [3:0] rd;

  assign rd = {READ4, READ3, READ2, READ1};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ERASE) lat[k] <= 8'd0;
      else if (DATA_OE && DATA_OUT == code[k]) lat[k] <= DATA_OUT;
    end
  end

  assign DATA_IN = READ1 ? lat[0] : READ2 ? lat[1] :
                   READ3 ? lat[2] : READ4 ? lat[3] : 8'h00;

  typedef struct {
    int         cyc;
    logic       busy, erase, expose, ramp, oe;
    logic [7:0] dout;
    logic [3:0] rd;
    logic       v;
    logic [1:0] idx;
    logic [7:0] pd;
    logic       fd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input bit use_tbl, input int stall_pix,
                           input int stall_len, input bit glitch,
                           input bit restart, input bit do_start,
                           input int exp_done, input string nm);
    int erase_cnt = 0, expose_cnt = 0, oe_cnt = 0;
    int ramp_err = 0, inv_err = 0, stall_err = 0;
    int fd_cnt = 0, done_cyc = 0, nx = 0, stall_left = stall_len;
    bit prev_stall = 0, rdy;
    logic [7:0] sd = '0;
    logic [1:0] si = '0;
    logic [9:0] xf [4] = '{default: '0};
    logic [9:0] xexp [4];
    xexp[0] = {2'd0, 8'd17};
    xexp[1] = {2'd1, 8'd200};
    xexp[2] = {2'd2, 8'd0};
    xexp[3] = {2'd3, 8'd255};
    if (do_start) begin
      @(negedge clk); START = 1'b1;
      @(negedge clk); START = 1'b0;
    end
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        if (FRAME_DONE) fd_cnt++;
        break;
      end
      if (DATA_OE && rd != 4'd0) inv_err++;
      if ($countones(rd) > 1) inv_err++;
      if (RESET != ERASE || RAMP_EN != DATA_OE) inv_err++;
      if (int'(ERASE) + int'(EXPOSE) + int'(RAMP_EN) > 1) inv_err++;
      if (!BUSY && (ERASE || EXPOSE || DATA_OE || rd != 0)) inv_err++;
      if (ERASE) erase_cnt++;
      if (EXPOSE) expose_cnt++;
      if (DATA_OE) begin
        if (DATA_OUT != 8'(oe_cnt)) ramp_err++;
        oe_cnt++;
      end
      if (FRAME_DONE) begin
        fd_cnt++;
        done_cyc = cyc;
      end
      if (use_tbl) begin
        for (int i = 0; i < 17; i++) begin
          if (tbl[i].cyc == cyc) begin
            chk($sformatf("%s vec cyc %0d", nm, cyc),
                {BUSY, ERASE, EXPOSE, RAMP_EN, DATA_OE, DATA_OUT, rd,
                 PIX_VALID, PIX_IDX, PIX_DATA, FRAME_DONE},
                {tbl[i].busy, tbl[i].erase, tbl[i].expose, tbl[i].ramp,
                 tbl[i].oe, tbl[i].dout, tbl[i].rd, tbl[i].v,
                 tbl[i].idx, tbl[i].pd, tbl[i].fd});
          end
        end
      end
      if (prev_stall) begin
        if (!(PIX_VALID && PIX_DATA == sd && PIX_IDX == si && rd == 0))
          stall_err++;
      end
      rdy = 1'b1;
      if (PIX_VALID && int'(PIX_IDX) == stall_pix && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        if (!prev_stall) begin
          sd = PIX_DATA;
          si = PIX_IDX;
        end
      end
      prev_stall = !rdy;
      PIX_READY = rdy;
      if (PIX_VALID && rdy) begin
        if (nx < 4) xf[nx] = {PIX_IDX, PIX_DATA};
        nx++;
      end
      START = 1'b0;
      if (glitch && (cyc == 100 || cyc == 520)) START = 1'b1;
      if (restart && FRAME_DONE) START = 1'b1;
      @(negedge clk);
    end
    PIX_READY = 1'b1;
    chk({nm, " erase_cycles"}, erase_cnt, 5);
    chk({nm, " expose_cycles"}, expose_cnt, 255);
    chk({nm, " convert_cycles"}, oe_cnt, 256);
    chk({nm, " ramp_errors"}, ramp_err, 0);
    chk({nm, " bus_invariant"}, inv_err, 0);
    chk({nm, " stall_hold"}, stall_err, 0);
    chk({nm, " stall_used"}, stall_left, 0);
    chk({nm, " frame_done_width"}, fd_cnt, 1);
    chk({nm, " frame_done_cycle"}, done_cyc, exp_done);
    chk({nm, " transfers"}, nx, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s xfer%0d", nm, i), xf[i], xexp[i]);
  endtask

  initial begin
    int bad;
    int done_b;
    reset_n = 1'b0;
    START = 1'b0;
    START_b = 1'b0;
    PIX_READY = 1'b1;
    //         cyc bsy er ex rmp oe dout rd      v  idx pd    fd
    tbl[0]  = '{1,   1, 1, 0, 0, 0, 8'd0,   4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[1]  = '{5,   1, 1, 0, 0, 0, 8'd0,   4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[2]  = '{6,   1, 0, 1, 0, 0, 8'd0,   4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[3]  = '{260, 1, 0, 1, 0, 0, 8'd0,   4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[4]  = '{261, 1, 0, 0, 1, 1, 8'd0,   4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[5]  = '{361, 1, 0, 0, 1, 1, 8'd100, 4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[6]  = '{516, 1, 0, 0, 1, 1, 8'd255, 4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[7]  = '{517, 1, 0, 0, 0, 0, 8'd0,   4'b0000, 0, 2'd0, 8'd0,   0};
    tbl[8]  = '{518, 1, 0, 0, 0, 0, 8'd0,   4'b0001, 0, 2'd0, 8'd0,   0};
    tbl[9]  = '{519, 1, 0, 0, 0, 0, 8'd0,   4'b0001, 0, 2'd0, 8'd0,   0};
    tbl[10] = '{520, 1, 0, 0, 0, 0, 8'd0,   4'b0000, 1, 2'd0, 8'd17,  0};
    tbl[11] = '{521, 1, 0, 0, 0, 0, 8'd0,   4'b0010, 0, 2'd0, 8'd17,  0};
    tbl[12] = '{523, 1, 0, 0, 0, 0, 8'd0,   4'b0000, 1, 2'd1, 8'd200, 0};
    tbl[13] = '{528, 1, 0, 0, 0, 0, 8'd0,   4'b1000, 0, 2'd2, 8'd0,   0};
    tbl[14] = '{529, 1, 0, 0, 0, 0, 8'd0,   4'b0000, 1, 2'd3, 8'd255, 0};
    tbl[15] = '{530, 0, 0, 0, 0, 0, 8'd0,   4'b0000, 0, 2'd3, 8'd255, 1};
    tbl[16] = '{531, 0, 0, 0, 0, 0, 8'd0,   4'b0000, 0, 2'd3, 8'd255, 0};

    #3;
    chk("reset_state", {BUSY, ERASE, RESET, EXPOSE, RAMP_EN, rd, DATA_OE,
        PIX_VALID, FRAME_DONE, DATA_OUT, PIX_DATA, PIX_IDX}, 0);
    chk("reset_state_b", {BUSY_b, ERASE_b, EXPOSE_b, DATA_OE_b,
        PIX_VALID_b, FRAME_DONE_b}, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    run_frame(1, -1, 0, 0, 0, 1, 530, "default");
    run_frame(0, 1, 10, 0, 0, 1, 540, "stall");
    run_frame(0, -1, 0, 1, 1, 1, 530, "glitch");
    run_frame(0, -1, 0, 0, 0, 0, 530, "back2back");

    // Reset asserted in the middle of the conversion ramp
    @(negedge clk); START = 1'b1;
    @(negedge clk); START = 1'b0;
    repeat (360) @(negedge clk);
    chk("pre_reset_count", {DATA_OE, DATA_OUT}, {1'b1, 8'd100});
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", {BUSY, ERASE, RESET, EXPOSE, RAMP_EN, rd, DATA_OE,
        PIX_VALID, FRAME_DONE, DATA_OUT, PIX_DATA, PIX_IDX}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (BUSY || PIX_VALID || FRAME_DONE || DATA_OE) bad++;
    end
    chk("no_resume_after_reset", bad, 0);
    run_frame(0, -1, 0, 0, 0, 1, 530, "post_reset");

    // Minimum erase/expose lengths
    @(negedge clk); START_b = 1'b1;
    @(negedge clk); START_b = 1'b0;
    chk("min c1", {ERASE_b, RESET_b, EXPOSE_b, RAMP_EN_b}, 4'b1100);
    @(negedge clk);
    chk("min c2", {ERASE_b, RESET_b, EXPOSE_b, RAMP_EN_b}, 4'b0010);
    @(negedge clk);
    chk("min c3", {ERASE_b, EXPOSE_b, RAMP_EN_b, DATA_OE_b, DATA_OUT_b},
        {4'b0011, 8'd0});
    done_b = 0;
    for (int cyc = 4; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc == 262)
        chk("min pix0", {PIX_VALID_b, PIX_IDX_b, PIX_DATA_b},
            {1'b1, 2'd0, 8'h5A});
      if (FRAME_DONE_b) begin
        done_b = cyc;
        break;
      end
    end
    chk("min frame_done_cycle", done_b, 272);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
